// File: rtl/mux_sched_pkg.sv
// Shared constants, FSM state type and select decode for the round-robin
// scheduler in front of the 8:1 dataflow mux.
package mux_sched_pkg;

    localparam int N      = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N-1:0] vec;
        vec = N'(1) << sel;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping, with ptr itself examined last.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] start_s;
    logic [N-1:0]     rot_s;
    logic [SEL_W-1:0] idx_s;

    // start wraps 7 -> 0, which is exactly the "no rotation" case
    assign start_s = ptr + SEL_W'(1);

    // rotate so the search start sits at bit 0, then take the lowest set bit
    always_comb begin
        rot_s = N'({req, req} >> start_s);
        idx_s = SEL_W'(0);
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                idx_s = SEL_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign winner = idx_s + start_s;
    assign any    = |req;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the mux_dataflow select lines, holding each
// grant for a programmable slot and flagging when the mux output is valid.
module mux_rr_sched
    import mux_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N-1:0]      req,
    input  logic [HOLD_W-1:0] hold_len,
    output logic [SEL_W-1:0]  sel,
    output logic [N-1:0]      grant,
    output logic              valid,
    output logic              slot_end
);

    state_e            state_r;
    logic [HOLD_W-1:0] cnt_r;
    logic [SEL_W-1:0]  ptr_r;
    logic [SEL_W-1:0]  sel_r;
    logic [N-1:0]      grant_r;
    logic              valid_r;

    logic [SEL_W-1:0]  win_s;
    logic              any_s;
    logic              slot_done_s;
    logic              issue_s;
    logic [HOLD_W-1:0] load_cnt_s;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (win_s),
        .any    (any_s)
    );

    // Slot termination (count exhausted or owner released) and grant decision
    always_comb begin
        slot_done_s = 1'b0;
        issue_s     = 1'b0;
        load_cnt_s  = HOLD_W'(0);
        if (state_r == HOLD) begin
            slot_done_s = (cnt_r == HOLD_W'(0)) || !req[sel_r];
        end else begin
            slot_done_s = 1'b0;
        end
        issue_s = en && any_s && ((state_r == IDLE) || slot_done_s);
        // a zero slot length behaves as a one-cycle slot
        if (hold_len == HOLD_W'(0)) begin
            load_cnt_s = HOLD_W'(0);
        end else begin
            load_cnt_s = hold_len - HOLD_W'(1);
        end
    end

    // FSM, slot counter, last-grant pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= HOLD_W'(0);
            ptr_r   <= SEL_W'(N - 1);
            sel_r   <= SEL_W'(0);
            grant_r <= N'(0);
            valid_r <= 1'b0;
        end else if (issue_s) begin
            state_r <= HOLD;
            cnt_r   <= load_cnt_s;
            ptr_r   <= win_s;
            sel_r   <= win_s;
            grant_r <= onehot(win_s);
            valid_r <= 1'b1;
        end else if (slot_done_s) begin
            // sel keeps its last value so the mux input does not glitch
            state_r <= IDLE;
            grant_r <= N'(0);
            valid_r <= 1'b0;
        end else if (state_r == HOLD) begin
            cnt_r <= cnt_r - HOLD_W'(1);
        end
    end

    assign sel      = sel_r;
    assign grant    = grant_r;
    assign valid    = valid_r;
    // early release must be visible in the same cycle the owner drops req
    assign slot_end = slot_done_s;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed scenarios plus randomized
// traffic against a slot-level reference model.
module tb_mux_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [3:0] hold_len;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       slot_end;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who owns the mux, how many cycles remain in the slot
    bit m_valid;
    int m_sel;
    int m_ptr;
    int m_rem;

    mux_rr_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .hold_len (hold_len),
        .sel      (sel),
        .grant    (grant),
        .valid    (valid),
        .slot_end (slot_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = 8'd0;
        if (m_valid) g[m_sel] = 1'b1;
        return g;
    endfunction

    function automatic bit m_slot_end();
        return m_valid && (m_rem == 1 || req[m_sel] == 1'b0);
    endfunction

    function automatic logic [12:0] m_outs();
        return {3'(m_sel), m_grant(), m_valid, m_slot_end()};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sel   = 0;
        m_ptr   = 7;
        m_rem   = 0;
    endtask

    // advance the model over one rising edge, then the clock itself
    task automatic step();
        bit ending;
        int w;
        ending = m_slot_end();
        if (en && req != 8'd0 && (!m_valid || ending)) begin
            w = -1;
            for (int k = 1; k <= 8; k++)
                if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
            m_sel   = w;
            m_ptr   = w;
            m_rem   = (hold_len == 4'd0) ? 1 : int'(hold_len);
            m_valid = 1'b1;
        end else if (ending) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_rem = m_rem - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 8'd0;
        hold_len = 4'd0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst_n = 1'b0;
        en = 1'b0; req = 8'd0; hold_len = 4'd0;
        #12;
        obs = {sel, grant, valid, slot_end};
        n_checks++;
        if (obs !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h want %h", obs, 13'd0);
        end
        do_reset();
        obs = {sel, grant, valid, slot_end};
        n_checks++;
        if (obs !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_idle: got %h want %h", obs, 13'd0);
        end
    endtask

    task automatic test_single();
        logic [12:0] obs, exp;
        do_reset();
        en = 1'b1; req = 8'h08; hold_len = 4'd3;
        step();
        for (int c = 0; c < 6; c++) begin
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = {3'd3, 8'h08, 1'b1, 1'(c % 3 == 2)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL single_regrant cyc %0d: got %h want %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_all_req();
        logic [12:0] obs, exp;
        logic [7:0]  one;
        do_reset();
        en = 1'b1; req = 8'hFF; hold_len = 4'd1;
        step();
        for (int c = 0; c < 9; c++) begin
            #1;
            one = 8'd1 << (c % 8);
            obs = {sel, grant, valid, slot_end};
            exp = {3'(c % 8), one, 1'b1, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL all_req_rotation cyc %0d: got %h want %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_early_release();
        logic [12:0] obs, exp;
        logic [7:0]  drop_val;
        for (int v = 0; v < 2; v++) begin
            drop_val = (v == 0) ? 8'h42 : 8'h00;
            do_reset();
            en = 1'b1; req = 8'h20; hold_len = 4'd4;
            step();
            step();
            req = drop_val;
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = {3'd5, 8'h20, 1'b1, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL early_release_pulse v%0d: got %h want %h", v, obs, exp);
            end
            step();
            obs = {sel, grant, valid};
            exp = (v == 0) ? {3'd6, 8'h40, 1'b1, 1'b0} : {3'd5, 8'h00, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp[12:1]) begin
                n_errors++;
                $display("FAIL early_release_next v%0d: got %h want %h", v, obs, exp[12:1]);
            end
        end
    endtask

    task automatic test_hold_zero();
        logic [12:0] obs, exp;
        do_reset();
        en = 1'b1; req = 8'h11; hold_len = 4'd0;
        step();
        for (int c = 0; c < 6; c++) begin
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = (c % 2 == 0) ? {3'd0, 8'h01, 1'b1, 1'b1} : {3'd4, 8'h10, 1'b1, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL hold_zero cyc %0d: got %h want %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_en_drop();
        logic [12:0] obs, exp;
        do_reset();
        en = 1'b1; req = 8'h03; hold_len = 4'd3;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = (c < 3) ? {3'd0, 8'h01, 1'b1, 1'(c == 2)} : 13'd0;
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL en_drop cyc %0d: got %h want %h", c, obs, exp);
            end
            en = 1'b0;
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [12:0] obs, exp;
        do_reset();
        en = 1'b1; req = 8'h20; hold_len = 4'd8;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        obs = {sel, grant, valid, slot_end};
        n_checks++;
        if (obs !== 13'd0) begin
            n_errors++;
            $display("FAIL async_reset_immediate: got %h want %h", obs, 13'd0);
        end
        model_reset();
        req = 8'h81; hold_len = 4'd1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = (c == 1) ? {3'd7, 8'h80, 1'b1, 1'b1} : {3'd0, 8'h01, 1'b1, 1'b1};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL async_reset_restart cyc %0d: got %h want %h", c, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [12:0] obs, exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom & $urandom);
            hold_len = 4'($urandom_range(0, 15));
            #1;
            obs = {sel, grant, valid, slot_end};
            exp = m_outs();
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL random_vs_model cyc %0d: got %h want %h", c, obs, exp);
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 8'd0; hold_len = 4'd0;
        model_reset();
        test_reset();
        test_single();
        test_all_req();
        test_early_release();
        test_hold_zero();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
